// File: rtl/pipelined_cla_adder_pkg.sv
// Shared widths and lookahead types for the pipelined carry-lookahead adder.
package AdderPkg;

    localparam int GROUP_WIDTH = 4;
    localparam int WORD_WIDTH  = 16;

    typedef struct packed {
        logic p;
        logic g;
    } group_pg_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle between the control sequencer and the adder.
interface pipelined_cla_adder_if
    import AdderPkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow_out;
    logic             zero_out;
    logic             valid_out;
    logic             ready_in;

    modport master (
        output a_in, b_in, c_in, valid_in, ready_in,
        input  ready_out, sum_out, carry_out, overflow_out, zero_out, valid_out
    );

    modport slave (
        input  a_in, b_in, c_in, valid_in, ready_in,
        output ready_out, sum_out, carry_out, overflow_out, zero_out, valid_out
    );

endinterface

// File: rtl/pipelined_cla_adder_cla.sv
// 4-bit lookahead unit and the per-bit partial full adder cell.
// Propagate is the OR form (p = a | b), so carries stay exact but p cannot form the sum.
module CarryLookaheadUnit
    import AdderPkg::*;
(
    input  logic [GROUP_WIDTH-1:0] p,
    input  logic [GROUP_WIDTH-1:0] g,
    input  logic                   c_in,
    output logic [GROUP_WIDTH:0]   carries,
    output group_pg_t              group_pg
);

    logic group_p;
    logic group_g;

    assign group_p = &p;
    assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign carries[0] = c_in;
    assign carries[1] = g[0] | (p[0] & c_in);
    assign carries[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign carries[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign carries[4] = group_g | (group_p & c_in);

    assign group_pg.p = group_p;
    assign group_pg.g = group_g;

endmodule

module PartialFullAdder (
    input  logic a,
    input  logic b,
    input  logic carry,
    output logic p,
    output logic g,
    output logic sum
);

    assign p   = a | b;
    assign g   = a & b;
    assign sum = a ^ b ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage CLA adder: S1 registers operands plus group P/G, S2 resolves carries into the output register.
// WIDTH/GROUP_WIDTH must not exceed GROUP_WIDTH so a single second-level unit covers all groups.
module pipelined_cla_adder
    import AdderPkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
)(
    input  logic                  clk_in,
    input  logic                  reset_in,
    pipelined_cla_adder_if.slave  bus
);

    localparam int NUM_GROUPS = WIDTH / GROUP_WIDTH;

    logic                   s1_valid;
    logic                   advance;
    logic                   accept;
    logic [WIDTH-1:0]       s1_a;
    logic [WIDTH-1:0]       s1_b;
    logic                   s1_c;
    group_pg_t              s1_group   [NUM_GROUPS];
    group_pg_t              next_group [NUM_GROUPS];
    logic [GROUP_WIDTH:0]   unused_s1_carries [NUM_GROUPS];

    assign advance       = !bus.valid_out || bus.ready_in;
    assign bus.ready_out = !s1_valid || advance;
    assign accept        = bus.valid_in && bus.ready_out;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_s1
        logic [GROUP_WIDTH-1:0] in_p;
        logic [GROUP_WIDTH-1:0] in_g;

        assign in_p = bus.a_in[gi*GROUP_WIDTH +: GROUP_WIDTH] | bus.b_in[gi*GROUP_WIDTH +: GROUP_WIDTH];
        assign in_g = bus.a_in[gi*GROUP_WIDTH +: GROUP_WIDTH] & bus.b_in[gi*GROUP_WIDTH +: GROUP_WIDTH];

        CarryLookaheadUnit u_cla (
            .p        (in_p),
            .g        (in_g),
            .c_in     (1'b0),
            .carries  (unused_s1_carries[gi]),
            .group_pg (next_group[gi])
        );
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            s1_valid <= 1'b0;
        end else if (bus.ready_out) begin
            s1_valid <= bus.valid_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            s1_a     <= bus.a_in;
            s1_b     <= bus.b_in;
            s1_c     <= bus.c_in;
            s1_group <= next_group;
        end
    end

    logic [GROUP_WIDTH-1:0] top_p;
    logic [GROUP_WIDTH-1:0] top_g;
    logic [GROUP_WIDTH:0]   top_carries;
    group_pg_t              unused_top_pg;

    // Unused second-level slots are padded with p = g = 0 so they never pass a carry.
    for (genvar gi = 0; gi < GROUP_WIDTH; gi++) begin : g_top
        if (gi < NUM_GROUPS) begin : g_used
            assign top_p[gi] = s1_group[gi].p;
            assign top_g[gi] = s1_group[gi].g;
        end else begin : g_pad
            assign top_p[gi] = 1'b0;
            assign top_g[gi] = 1'b0;
        end
    end

    CarryLookaheadUnit u_top_cla (
        .p        (top_p),
        .g        (top_g),
        .c_in     (s1_c),
        .carries  (top_carries),
        .group_pg (unused_top_pg)
    );

    logic [WIDTH-1:0]       bit_p;
    logic [WIDTH-1:0]       bit_g;
    logic [WIDTH-1:0]       bit_carry;
    logic [WIDTH-1:0]       next_sum;
    logic [GROUP_WIDTH:0]   group_carries [NUM_GROUPS];
    logic [NUM_GROUPS-1:0]  unused_group_couts;
    group_pg_t              unused_s2_pg [NUM_GROUPS];

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_s2
        CarryLookaheadUnit u_cla (
            .p        (bit_p[gi*GROUP_WIDTH +: GROUP_WIDTH]),
            .g        (bit_g[gi*GROUP_WIDTH +: GROUP_WIDTH]),
            .c_in     (top_carries[gi]),
            .carries  (group_carries[gi]),
            .group_pg (unused_s2_pg[gi])
        );

        assign bit_carry[gi*GROUP_WIDTH +: GROUP_WIDTH] = group_carries[gi][GROUP_WIDTH-1:0];
        assign unused_group_couts[gi] = group_carries[gi][GROUP_WIDTH];
    end

    for (genvar bi = 0; bi < WIDTH; bi++) begin : g_bit
        PartialFullAdder u_pfa (
            .a     (s1_a[bi]),
            .b     (s1_b[bi]),
            .carry (bit_carry[bi]),
            .p     (bit_p[bi]),
            .g     (bit_g[bi]),
            .sum   (next_sum[bi])
        );
    end

    logic next_carry;
    logic next_overflow;

    assign next_carry    = top_carries[NUM_GROUPS];
    assign next_overflow = bit_carry[WIDTH-1] ^ next_carry;

    // Result data only moves when a real operation leaves S1, so a stalled output stays put.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bus.valid_out    <= 1'b0;
            bus.sum_out      <= '0;
            bus.carry_out    <= 1'b0;
            bus.overflow_out <= 1'b0;
            bus.zero_out     <= 1'b0;
        end else begin
            if (advance) begin
                bus.valid_out <= s1_valid;
            end
            if (advance && s1_valid) begin
                bus.sum_out      <= next_sum;
                bus.carry_out    <= next_carry;
                bus.overflow_out <= next_overflow;
                bus.zero_out     <= (next_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases plus a randomized run scored
// against a queue-based arithmetic model of the two-slot pipeline.
module tb_pipelined_cla_adder;
    import AdderPkg::*;

    typedef struct {
        logic [WORD_WIDTH-1:0] sum;
        logic                  carry;
        logic                  ovf;
        logic                  zero;
        int                    cycle;
    } obs_t;

    logic clk_in = 1'b0;
    logic reset_in;
    always #5 clk_in = ~clk_in;

    pipelined_cla_adder_if #(.WIDTH(WORD_WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WORD_WIDTH)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    int   compare_count  = 0;
    int   mismatch_count = 0;
    int   cycle_count    = 0;
    logic checking       = 1'b0;
    logic rand_run       = 1'b0;

    logic [WORD_WIDTH+2:0] model_q [$];
    logic                  model_out_valid = 1'b0;
    logic                  exp_ready;
    obs_t                  result_log [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected {carry, overflow, zero, sum} straight from integer addition.
    function automatic logic [WORD_WIDTH+2:0] refResult(input logic [WORD_WIDTH-1:0] a,
                                                         input logic [WORD_WIDTH-1:0] b,
                                                         input logic c);
        logic [WORD_WIDTH:0]   full;
        logic [WORD_WIDTH-1:0] s;
        logic                  ovf;
        full = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, c};
        s    = full[WORD_WIDTH-1:0];
        ovf  = (a[WORD_WIDTH-1] == b[WORD_WIDTH-1]) && (s[WORD_WIDTH-1] != a[WORD_WIDTH-1]);
        return {full[WORD_WIDTH], ovf, (s == '0), s};
    endfunction

    function automatic logic [WORD_WIDTH-1:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return WORD_WIDTH'($urandom);
        endcase
    endfunction

    // Scoreboard: at most two operations in flight, oldest presented once it has left S1.
    always @(negedge clk_in) begin
        logic out_xfer;
        logic acc;
        cycle_count++;
        exp_ready = (model_q.size() < 2) || bus.ready_in;
        if (checking) begin
            checkOutput("mon_ready_out", {31'd0, bus.ready_out}, {31'd0, exp_ready});
            checkOutput("mon_valid_out", {31'd0, bus.valid_out}, {31'd0, model_out_valid});
            if (model_out_valid) begin
                checkOutput("mon_result", {13'd0, bus.carry_out, bus.overflow_out, bus.zero_out, bus.sum_out},
                            {13'd0, model_q[0]});
            end
        end
        if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
            result_log.push_back('{bus.sum_out, bus.carry_out, bus.overflow_out, bus.zero_out, cycle_count});
        end
        if (reset_in) begin
            model_q.delete();
            model_out_valid = 1'b0;
        end else begin
            out_xfer = model_out_valid && bus.ready_in;
            acc      = bus.valid_in && exp_ready;
            if (out_xfer) void'(model_q.pop_front());
            model_out_valid = (model_q.size() > 0);
            if (acc) model_q.push_back(refResult(bus.a_in, bus.b_in, bus.c_in));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operands.
    task automatic applyStimulus(input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b, input logic c);
        logic accepted;
        accepted     = 1'b0;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.c_in     = c;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk_in);
            if (bus.ready_out === 1'b1) accepted = 1'b1;
            @(posedge clk_in);
            #1;
        end
        bus.valid_in = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitForResults(input string tag, input int count);
        for (int i = 0; i < 400 && result_log.size() < count; i++) @(posedge clk_in);
        checkOutput(tag, result_log.size(), count);
    endtask

    task automatic checkLogEntry(input string tag, input int idx, input logic [WORD_WIDTH-1:0] sum,
                                 input logic carry, input logic ovf, input logic zero);
        if (result_log.size() > idx) begin
            checkOutput({tag, "_sum"},   {16'd0, result_log[idx].sum},   {16'd0, sum});
            checkOutput({tag, "_carry"}, {31'd0, result_log[idx].carry}, {31'd0, carry});
            checkOutput({tag, "_ovf"},   {31'd0, result_log[idx].ovf},   {31'd0, ovf});
            checkOutput({tag, "_zero"},  {31'd0, result_log[idx].zero},  {31'd0, zero});
        end
    endtask

    initial begin
        #800000;
        checkOutput("watchdog_timeout", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

    initial begin
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.c_in     = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        reset_in     = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 reset_in = 1'b0;

        @(negedge clk_in);
        checkOutput("rst_valid_out", {31'd0, bus.valid_out},    32'd0);
        checkOutput("rst_ready_out", {31'd0, bus.ready_out},    32'd1);
        checkOutput("rst_sum",       {16'd0, bus.sum_out},      32'd0);
        checkOutput("rst_carry",     {31'd0, bus.carry_out},    32'd0);
        checkOutput("rst_ovf",       {31'd0, bus.overflow_out}, 32'd0);
        checkOutput("rst_zero",      {31'd0, bus.zero_out},     32'd0);
        checking = 1'b1;
        @(posedge clk_in);
        #1;

        // Latency and signed overflow into the sign bit.
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk_in);
        checkOutput("lat_not_yet", {31'd0, bus.valid_out}, 32'd0);
        @(negedge clk_in);
        checkOutput("lat_valid",   {31'd0, bus.valid_out},    32'd1);
        checkOutput("lat_sum",     {16'd0, bus.sum_out},      32'h8000);
        checkOutput("lat_carry",   {31'd0, bus.carry_out},    32'd0);
        checkOutput("lat_ovf",     {31'd0, bus.overflow_out}, 32'd1);
        checkOutput("lat_zero",    {31'd0, bus.zero_out},     32'd0);
        @(posedge clk_in);
        #1;

        // Wrap-around through the full carry chain, via operand and via carry-in.
        result_log.delete();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        waitForResults("wrap_count", 2);
        checkLogEntry("wrap_b", 0, 16'h0000, 1'b1, 1'b0, 1'b1);
        checkLogEntry("wrap_c", 1, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk_in);
        #1;

        // Back-to-back at full throughput.
        result_log.delete();
        applyStimulus(16'h1234, 16'h4321, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        applyStimulus(16'h00FF, 16'h0F01, 1'b0);
        waitForResults("b2b_count", 3);
        checkLogEntry("b2b_0", 0, 16'h5556, 1'b0, 1'b0, 1'b0);
        checkLogEntry("b2b_1", 1, 16'h0000, 1'b1, 1'b1, 1'b1);
        checkLogEntry("b2b_2", 2, 16'h1000, 1'b0, 1'b0, 1'b0);
        if (result_log.size() >= 3) begin
            checkOutput("b2b_gap01", result_log[1].cycle - result_log[0].cycle, 32'd1);
            checkOutput("b2b_gap12", result_log[2].cycle - result_log[1].cycle, 32'd1);
        end
        @(posedge clk_in);
        #1;

        // Backpressure: two held operations, outputs frozen, then ordered release.
        result_log.delete();
        bus.ready_in = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b1);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        bus.a_in     = 16'h00FF;
        bus.b_in     = 16'h0F01;
        bus.c_in     = 1'b0;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            checkOutput("bp_ready_low", {31'd0, bus.ready_out}, 32'd0);
            checkOutput("bp_hold_valid", {31'd0, bus.valid_out}, 32'd1);
            checkOutput("bp_hold_sum", {16'd0, bus.sum_out}, 32'h5556);
        end
        @(posedge clk_in);
        #1 bus.ready_in = 1'b1;
        applyStimulus(16'h00FF, 16'h0F01, 1'b0);
        waitForResults("bp_count", 3);
        checkLogEntry("bp_0", 0, 16'h5556, 1'b0, 1'b0, 1'b0);
        checkLogEntry("bp_1", 1, 16'h0000, 1'b1, 1'b1, 1'b1);
        checkLogEntry("bp_2", 2, 16'h1000, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk_in);
        checkOutput("bp_no_dup", result_log.size(), 32'd3);
        #1;

        // Reset with both stages occupied discards everything.
        result_log.delete();
        bus.ready_in = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        applyStimulus(16'h3333, 16'h4444, 1'b1);
        reset_in = 1'b1;
        @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        checkOutput("mid_rst_valid", {31'd0, bus.valid_out},    32'd0);
        checkOutput("mid_rst_ready", {31'd0, bus.ready_out},    32'd1);
        checkOutput("mid_rst_sum",   {16'd0, bus.sum_out},      32'd0);
        checkOutput("mid_rst_carry", {31'd0, bus.carry_out},    32'd0);
        checkOutput("mid_rst_ovf",   {31'd0, bus.overflow_out}, 32'd0);
        checkOutput("mid_rst_zero",  {31'd0, bus.zero_out},     32'd0);
        @(posedge clk_in);
        #1 bus.ready_in = 1'b1;
        repeat (5) @(posedge clk_in);
        checkOutput("mid_rst_no_stale", result_log.size(), 32'd0);
        #1;

        // Randomized traffic with random gaps and random backpressure.
        result_log.delete();
        rand_run = 1'b1;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk_in);
                        #1;
                    end
                    applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)));
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk_in);
                    #1 bus.ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk_in);
        #1 bus.ready_in = 1'b1;
        waitForResults("rand_count", 10000);
        repeat (5) @(posedge clk_in);
        checkOutput("rand_no_dup", result_log.size(), 32'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
